// File: rtl/subtractor.sv
// subtractor: unsigned BITS-wide ripple-borrow subtractor with registered
// outputs and a one-cycle valid strobe.
// Optional build macro SUBTRACTOR_BORROW_IN_EN adds an i_borrow input that
// feeds the bit-0 borrow-in, so words can be chained for wide subtraction.

// One full-subtractor cell of the ripple-borrow chain.
module subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module subtractor #(
  parameter int BITS = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
`ifdef SUBTRACTOR_BORROW_IN_EN
  input  logic            i_borrow,
`endif
  input  logic [BITS-1:0] i_minuend,
  input  logic [BITS-1:0] i_subtrahend,
  output logic            o_valid,
  output logic [BITS-1:0] o_difference,
  output logic            o_borrow
);

  // chain[i] is the borrow into bit i; chain[BITS] is the final borrow-out.
  logic [BITS:0]   chain;
  logic [BITS-1:0] diff;
  logic            valid_q;
  logic [BITS-1:0] diff_q;
  logic            borrow_q;

`ifdef SUBTRACTOR_BORROW_IN_EN
  assign chain[0] = i_borrow;
`else
  assign chain[0] = 1'b0;
`endif

  for (genvar g = 0; g < BITS; g++) begin : g_cell
    subtractor_cell u_cell (
      .a    (i_minuend[g]),
      .b    (i_subtrahend[g]),
      .bin  (chain[g]),
      .d    (diff[g]),
      .bout (chain[g+1])
    );
  end

  // Valid strobe follows i_valid by one cycle; reset clears it.
  always_ff @(posedge i_clock) begin
    if (i_reset) valid_q <= 1'b0;
    else         valid_q <= i_valid;
  end

  // Result registers load only on i_valid and otherwise hold the last result.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (i_valid) begin
      diff_q   <= diff;
      borrow_q <= chain[BITS];
    end
  end

  assign o_valid      = valid_q;
  assign o_difference = diff_q;
  assign o_borrow     = borrow_q;

endmodule

// File: tb/tb_subtractor.sv
// Scoreboard bench for subtractor (BITS=4). Stimulus pushes the expected
// {borrow, difference} into a queue; a monitor pops and compares on o_valid.
module tb_subtractor;
  localparam int BITS = 4;

  logic            i_clock = 1'b0;
  logic            i_reset;
  logic            i_valid;
  logic            i_borrow;
  logic [BITS-1:0] i_minuend;
  logic [BITS-1:0] i_subtrahend;
  logic            o_valid;
  logic [BITS-1:0] o_difference;
  logic            o_borrow;

  int checks = 0;
  int errors = 0;
  logic [BITS:0] exp_q[$];
  bit done = 0;

  subtractor #(.BITS(BITS)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
`ifdef SUBTRACTOR_BORROW_IN_EN
    .i_borrow     (i_borrow),
`endif
    .i_minuend    (i_minuend),
    .i_subtrahend (i_subtrahend),
    .o_valid      (o_valid),
    .o_difference (o_difference),
    .o_borrow     (o_borrow)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Issue one operand pair; expected value is the plain integer difference
  // wrapped into a (BITS+1)-bit two's-complement word.
  task automatic issue(input int a, input int b, input int bin, input bit rst);
    logic [BITS:0] e;
    i_minuend    = BITS'(a);
    i_subtrahend = BITS'(b);
    i_borrow     = bin[0];
    i_valid      = 1'b1;
    i_reset      = rst;
    e = (BITS+1)'(a - b - bin);
    if (!rst) exp_q.push_back(e);
    @(posedge i_clock); #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_reset = 1'b0;
    repeat (n) begin @(posedge i_clock); #1; end
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  initial begin
    logic [BITS:0] e;
    forever begin
      @(negedge i_clock);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", int'({o_borrow, o_difference}), int'(e));
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_borrow = 1'b0;
    i_minuend = '0; i_subtrahend = '0;
    repeat (2) begin @(posedge i_clock); #1; end
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_diff",  int'(o_difference), 0);
    chk("reset_borrow", int'(o_borrow), 0);
    @(posedge i_clock); #1;

    // Directed vectors: expected {borrow,diff} values 6, {1,1010}, {1,0001},
    // {0,1111}, {0,0000}.
    issue(9, 3, 0, 0);
    issue(3, 9, 0, 0);
    issue(0, 15, 0, 0);
    issue(15, 0, 0, 0);
    issue(7, 7, 0, 0);
    idle(2);

    // Hold: after 3-9, dropping i_valid keeps diff=10, borrow=1.
    issue(3, 9, 0, 0);
    idle(1);
    @(negedge i_clock);
    chk("hold_valid", int'(o_valid), 0);
    chk("hold_diff", int'(o_difference), 10);
    chk("hold_borrow", int'(o_borrow), 1);
    @(posedge i_clock); #1;
    @(negedge i_clock);
    chk("hold2_diff", int'(o_difference), 10);
    chk("hold2_borrow", int'(o_borrow), 1);
    @(posedge i_clock); #1;

    // Reset wins over i_valid in the same cycle.
    issue(3, 9, 0, 1);
    i_valid = 1'b0; i_reset = 1'b0;
    @(negedge i_clock);
    chk("rstv_valid", int'(o_valid), 0);
    chk("rstv_diff", int'(o_difference), 0);
    chk("rstv_borrow", int'(o_borrow), 0);
    @(posedge i_clock); #1;
    // First post-reset result arrives one cycle after i_valid.
    issue(12, 5, 0, 0);
    i_valid = 1'b0;
    @(negedge i_clock);
    chk("post_rst_valid", int'(o_valid), 1);
    @(posedge i_clock); #1;

    // Exhaustive back-to-back sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        issue(x, y, 0, 0);
    idle(2);

`ifdef SUBTRACTOR_BORROW_IN_EN
    // 0-15-1 = -16 -> diff 0, borrow 1.
    issue(0, 15, 1, 0);
    issue(15, 0, 1, 0);
    issue(5, 5, 1, 0);
    idle(2);
`endif

    chk("queue_drained", exp_q.size(), 0);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
    end
  end
endmodule

// File: doc/subtractor.md
Name: subtractor

Overview:
- Parameterised unsigned binary subtractor with registered outputs.
- Computes minuend − subtrahend and reports the difference plus a borrow-out flag.
- {borrow, difference} read as a signed (BITS+1)-bit number equals the true mathematical difference.
- Used as a datapath leaf wherever a bounded unsigned subtraction with underflow indication is needed.

Parameters:
- BITS, 4, operand and difference width in bits (legal range 1..64).

Ports:
- i_clock  input  1  rising-edge clock
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  operands valid this cycle; capture and compute
- i_minuend  input  BITS  unsigned minuend
- i_subtrahend  input  BITS  unsigned subtrahend
- o_valid  output  1  registered result valid strobe
- o_difference  output  BITS  registered difference, modulo 2^BITS
- o_borrow  output  1  registered borrow-out; 1 when minuend < subtrahend

Behaviour:
- All outputs are flops updated on the rising edge of i_clock. No combinational path from inputs to outputs.
- Reset:
  - i_reset high at a clock edge forces o_valid=0, o_difference=0, o_borrow=0.
  - Reset has priority over i_valid.
  - Reset mid-operation discards any in-flight result; the first post-reset result appears one cycle after the first i_valid.
- Latency is exactly 1 cycle. i_valid high at edge N → o_valid high after edge N, with that cycle's result. Back-to-back i_valid gives one result per cycle, with no bubbles and no backpressure.
- When i_valid is low at an edge:
  - o_valid goes to 0.
  - o_difference and o_borrow hold their previous values.
- Arithmetic:
  - Ripple-borrow chain of BITS full-subtractor cells. Bit 0 borrow-in is 0.
  - Per bit: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
  - o_borrow = borrow out of the MSB cell.
  - o_difference = (minuend − subtrahend) mod 2^BITS.
  - Invariant: signed value of {o_borrow, o_difference} = minuend − subtrahend for all minuend, subtrahend in [0, 2^BITS−1].
  - Result range is −(2^BITS−1)..+(2^BITS−1), so no overflow is possible.
- Boundaries:
  - Equal operands → difference 0, borrow 0.
  - 0 − max → difference 1, borrow 1.
  - max − 0 → difference max, borrow 0.
- Operands are unsigned. There is no signed operand mode.

Optional Feature:
- Macro: SUBTRACTOR_BORROW_IN_EN.
- Defined:
  - Adds port i_borrow (input, 1 bit), sampled with i_valid.
  - It feeds the bit-0 borrow-in, so the result is minuend − subtrahend − i_borrow.
  - Invariant: signed value of {o_borrow, o_difference} = minuend − subtrahend − i_borrow. Range extends to −2^BITS, still representable.
  - Enables multi-word subtraction by chaining o_borrow into the next word's i_borrow.
- Not defined: the port is absent and bit-0 borrow-in is tied to 0.

Test Plan:
- BITS=4; reset high for 2 cycles, then low → o_valid=0, o_difference=0, o_borrow=0.
- i_valid=1 with 9−3 → next cycle o_valid=1, o_difference=6, o_borrow=0.
- 3−9 → o_difference=10, o_borrow=1 ({1,1010} = −6).
- Boundaries:
  - 0−15 → o_difference=1, o_borrow=1 (−15).
  - 15−0 → o_difference=15, o_borrow=0.
  - 7−7 → o_difference=0, o_borrow=0.
- Exhaustive sweep of all 16×16 operand pairs with i_valid held high → every result matches x−y as a signed 5-bit value, one per cycle.
- Reset and valid interaction:
  - Assert i_reset in the same cycle as i_valid with 3−9 → outputs stay 0 and o_valid=0.
  - Drop i_valid after a result → o_valid=0 and prior difference/borrow are held.
- With SUBTRACTOR_BORROW_IN_EN defined: 0−15 with i_borrow=1 → o_difference=0, o_borrow=1 (−16).
